// File: rtl/predecode_fifo_if.sv
// Shared predecode types plus the fetch/issue-side bus of predecode_fifo.
// The master modport is the fetch/issue side; the slave modport is the queue itself.
package predecode_pkg;

    typedef enum logic [2:0] {
        B_INVA = 3'd0,
        B_EQNE = 3'd1,
        B_LTGE = 3'd2,
        B_JUMP = 3'd3,
        B_JREG = 3'd4
    } branch_type_e;

    typedef struct packed {
        logic [31:0]  instr;
        logic [31:0]  pc;
        branch_type_e btype;
        logic         is_branch;
        logic         is_link;
        logic         is_hilo;
        logic         is_delay_slot;
    } entry_t;

    // The delay-slot tag depends on neighbouring lanes, so the caller fills it in.
    function automatic entry_t predecode(input logic [31:0] instr, input logic [31:0] pc);
        entry_t     e;
        logic [5:0] op;
        logic [4:0] rt;
        logic [5:0] fn;
        op = instr[31:26];
        rt = instr[20:16];
        fn = instr[5:0];
        e        = '0;
        e.instr  = instr;
        e.pc     = pc;
        e.btype  = B_INVA;
        if (op[5:2] == 4'b0001) begin
            e.is_branch = 1'b1;
            e.btype     = B_EQNE;
        end else if (op == 6'b000001 && rt[3:1] == 3'b000) begin
            e.is_branch = 1'b1;
            e.btype     = B_LTGE;
            e.is_link   = rt[4];
        end else if (op[5:1] == 5'b00001) begin
            e.is_branch = 1'b1;
            e.btype     = B_JUMP;
            e.is_link   = op[0];
        end else if (op == 6'b000000 && fn[5:1] == 5'b00100) begin
            e.is_branch = 1'b1;
            e.btype     = B_JREG;
            e.is_link   = fn[0];
        end
        e.is_hilo = (op == 6'b000000 && (fn[5:2] == 4'b0100 || fn[5:2] == 4'b0110)) ||
                    (op == 6'b011100 && fn[5:3] == 3'b000 &&
                     fn[2:0] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        return e;
    endfunction

endpackage

interface predecode_fifo_if #(
    parameter int DEPTH     = 8,
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2
);
    logic                           flush;
    logic [IN_WIDTH-1:0]            in_valid;
    logic [32*IN_WIDTH-1:0]         in_instr;
    logic [32*IN_WIDTH-1:0]         in_pc;
    logic                           in_ready;
    logic [OUT_WIDTH-1:0]           out_valid;
    logic [32*OUT_WIDTH-1:0]        out_instr;
    logic [32*OUT_WIDTH-1:0]        out_pc;
    logic [3*OUT_WIDTH-1:0]         out_branch_type;
    logic [OUT_WIDTH-1:0]           out_is_branch;
    logic [OUT_WIDTH-1:0]           out_is_link;
    logic [OUT_WIDTH-1:0]           out_is_hilo;
    logic [OUT_WIDTH-1:0]           out_is_delay_slot;
    logic [$clog2(OUT_WIDTH+1)-1:0] out_pop;
    logic [$clog2(DEPTH+1)-1:0]     count;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_pop,
        input  in_ready, out_valid, out_instr, out_pc, out_branch_type,
               out_is_branch, out_is_link, out_is_hilo, out_is_delay_slot, count
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_pop,
        output in_ready, out_valid, out_instr, out_pc, out_branch_type,
               out_is_branch, out_is_link, out_is_hilo, out_is_delay_slot, count
    );
endinterface

// File: rtl/predecode_fifo.sv
// Predecoding circular queue between fetch and issue: up to IN_WIDTH pushes and
// OUT_WIDTH presented head entries per cycle, with pop-count handshake and flush.
module predecode_fifo
    import predecode_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    predecode_fifo_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(OUT_WIDTH + 1);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            prev_branch_q, prev_branch_d;

    entry_t          lane_e [IN_WIDTH];
    entry_t          head_e [OUT_WIDTH];
    logic [CW-1:0]   push_cnt;
    logic            last_branch;
    logic            push_en;
    logic            valid_chain;
    logic [OUT_WIDTH-1:0] out_valid_w;
    logic [PW-1:0]   valid_cnt;

    // A pop in the same cycle is deliberately not credited toward readiness.
    assign bus.in_ready = (CW'(DEPTH) - count_q) >= CW'(IN_WIDTH);
    assign push_en      = bus.in_ready && (|bus.in_valid) && !bus.flush;
    assign bus.count    = count_q;

    always_comb begin
        push_cnt    = '0;
        last_branch = prev_branch_q;
        for (int i = 0; i < IN_WIDTH; i++) begin
            lane_e[i] = predecode(bus.in_instr[32*i +: 32], bus.in_pc[32*i +: 32]);
        end
        lane_e[0].is_delay_slot = prev_branch_q;
        for (int i = 1; i < IN_WIDTH; i++) begin
            lane_e[i].is_delay_slot = lane_e[i-1].is_branch;
        end
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (bus.in_valid[i]) begin
                push_cnt    = push_cnt + CW'(1);
                last_branch = lane_e[i].is_branch;
            end
        end
    end

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        prev_branch_d = prev_branch_q;
        if (bus.flush) begin
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            prev_branch_d = 1'b0;
        end else begin
            head_d  = head_q + AW'(bus.out_pop);
            count_d = count_q - CW'(bus.out_pop);
            if (push_en) begin
                tail_d        = tail_q + AW'(push_cnt);
                count_d       = count_d + push_cnt;
                prev_branch_d = last_branch;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            prev_branch_q <= 1'b0;
            // NOTE: storage is cleared here so every out_* field reads zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            prev_branch_q <= prev_branch_d;
            if (push_en) begin
                for (int i = 0; i < IN_WIDTH; i++) begin
                    if (bus.in_valid[i]) begin
                        mem_q[tail_q + AW'(i)] <= lane_e[i];
                    end
                end
            end
        end
    end

    // A branch is held back until its delay slot is also in the queue.
    always_comb begin
        valid_chain           = 1'b1;
        out_valid_w           = '0;
        valid_cnt             = '0;
        bus.out_instr         = '0;
        bus.out_pc            = '0;
        bus.out_branch_type   = '0;
        bus.out_is_branch     = '0;
        bus.out_is_link       = '0;
        bus.out_is_hilo       = '0;
        bus.out_is_delay_slot = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            head_e[i]   = mem_q[head_q + AW'(i)];
            valid_chain = valid_chain && (count_q > CW'(i)) &&
                          !(head_e[i].is_branch && (count_q <= CW'(i + 1)));
            out_valid_w[i] = valid_chain;
            if (valid_chain) begin
                valid_cnt = valid_cnt + PW'(1);
            end
            bus.out_instr[32*i +: 32]     = head_e[i].instr;
            bus.out_pc[32*i +: 32]        = head_e[i].pc;
            bus.out_branch_type[3*i +: 3] = head_e[i].btype;
            bus.out_is_branch[i]          = head_e[i].is_branch;
            bus.out_is_link[i]            = head_e[i].is_link;
            bus.out_is_hilo[i]            = head_e[i].is_hilo;
            bus.out_is_delay_slot[i]      = head_e[i].is_delay_slot;
        end
        bus.out_valid = out_valid_w;
    end

    a_in_valid_contiguous : assert property (@(posedge clk) disable iff (rst)
        (bus.in_valid & (bus.in_valid + IN_WIDTH'(1))) == '0);

    a_pop_within_valid : assert property (@(posedge clk) disable iff (rst)
        bus.out_pop <= valid_cnt);

endmodule

// File: tb/tb_predecode_fifo.sv
// Randomised and directed bench for predecode_fifo: a queue-based reference model
// feeds a scoreboard that a free-running monitor compares against the head lanes.
module tb_predecode_fifo;
    import predecode_pkg::*;

    localparam int DEPTH     = 8;
    localparam int IN_WIDTH  = 2;
    localparam int OUT_WIDTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  btype;
        logic        br;
        logic        link;
        logic        hilo;
        logic        ds;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    bit   mon_en;
    bit   prev_br;
    exp_t exp_q[$];

    predecode_fifo_if #(.DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    predecode_fifo #(.DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference classification written straight from the opcode/function tables.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   op;
        int   rt;
        int   fn;
        op      = int'(w[31:26]);
        rt      = int'(w[20:16]);
        fn      = int'(w[5:0]);
        e       = '0;
        e.instr = w;
        e.pc    = pc;
        e.btype = B_INVA;
        if (op >= 4 && op <= 7) begin
            e.br = 1'b1; e.btype = B_EQNE;
        end else if (op == 1 && (rt % 16) < 2) begin
            e.br = 1'b1; e.btype = B_LTGE; e.link = (rt >= 16);
        end else if (op == 2 || op == 3) begin
            e.br = 1'b1; e.btype = B_JUMP; e.link = (op == 3);
        end else if (op == 0 && (fn == 8 || fn == 9)) begin
            e.br = 1'b1; e.btype = B_JREG; e.link = (fn == 9);
        end
        e.hilo = (op == 0 && ((fn >= 16 && fn <= 19) || (fn >= 24 && fn <= 27))) ||
                 (op == 28 && fn inside {0, 1, 2, 4, 5});
        return e;
    endfunction

    // A head entry is presentable if it exists, every entry before it is presentable,
    // and, when it is a branch, something is queued behind it.
    function automatic logic [1:0] model_valid();
        logic [1:0] v;
        bit         ok;
        v  = '0;
        ok = 1'b1;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (exp_q.size() <= i) ok = 1'b0;
            else if (exp_q[i].br && exp_q.size() < i + 2) ok = 1'b0;
            v[i] = ok;
        end
        return v;
    endfunction

    function automatic exp_t dut_lane(input int i);
        exp_t e;
        e.instr = bus.out_instr[32*i +: 32];
        e.pc    = bus.out_pc[32*i +: 32];
        e.btype = bus.out_branch_type[3*i +: 3];
        e.br    = bus.out_is_branch[i];
        e.link  = bus.out_is_link[i];
        e.hilo  = bus.out_is_hilo[i];
        e.ds    = bus.out_is_delay_slot[i];
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[31:26] = 6'($urandom_range(4, 7));
            1: w[31:26] = 6'd1;
            2: w[31:26] = 6'($urandom_range(2, 3));
            3: begin w[31:26] = 6'd0; w[5:0] = 6'($urandom_range(8, 9)); end
            4: begin w[31:26] = 6'd0; w[5:0] = 6'($urandom_range(16, 27)); end
            5: begin w[31:26] = 6'h1c; w[5:0] = 6'($urandom_range(0, 7)); end
            6: w[31:26] = 6'd0;
            default: ;
        endcase
        return w;
    endfunction

    // Monitor: compares every presented lane with the scoreboard, then retires popped entries.
    initial begin
        logic [1:0] ev;
        int         n;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                ev = model_valid();
                check("count", bus.count, exp_q.size());
                check("in_ready", bus.in_ready, (DEPTH - exp_q.size()) >= IN_WIDTH);
                check("out_valid", bus.out_valid, ev);
                for (int i = 0; i < OUT_WIDTH; i++) begin
                    if (ev[i]) check($sformatf("lane%0d", i), dut_lane(i), exp_q[i]);
                end
                if (bus.flush) begin
                    exp_q.delete();
                end else begin
                    n = int'(bus.out_pop);
                    repeat (n) if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; the expected entries enter the scoreboard once the edge has passed.
    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] p0, input logic [31:0] p1, input int pop, input bit fl);
        exp_t pend[$];
        exp_t e;
        bit   pb;
        bit   acc;
        int   mv;
        @(negedge clk);
        mv = $countones(model_valid());
        if (pop > mv) pop = mv;
        bus.in_valid = v;
        bus.in_instr = {i1, i0};
        bus.in_pc    = {p1, p0};
        bus.out_pop  = 2'(pop);
        bus.flush    = fl;
        acc = !fl && (v != 0) && ((DEPTH - exp_q.size()) >= IN_WIDTH);
        pb  = prev_br;
        if (v[0]) begin e = ref_decode(i0, p0); e.ds = pb; pb = e.br; pend.push_back(e); end
        if (v[1]) begin e = ref_decode(i1, p1); e.ds = pb; pb = e.br; pend.push_back(e); end
        @(posedge clk);
        #1;
        if (fl) begin
            prev_br = 1'b0;
        end else if (acc) begin
            foreach (pend[k]) exp_q.push_back(pend[k]);
            prev_br = pb;
        end
    endtask

    task automatic push1(input logic [31:0] w, input logic [31:0] pc);
        drive(2'b01, w, 32'h0, pc, 32'h0, 0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, n, 1'b0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        mon_en       = 1'b0;
        prev_br      = 1'b0;
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.in_valid = '0;
        bus.in_instr = '0;
        bus.in_pc    = '0;
        bus.out_pop  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_count", bus.count, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_btype", bus.out_branch_type, 0);
        check("rst_flags", {bus.out_is_branch, bus.out_is_link, bus.out_is_hilo, bus.out_is_delay_slot}, 0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Two plain ALU ops.
        drive(2'b11, 32'h0000_0000, 32'h0085_1020, 32'h100, 32'h104, 0, 1'b0);
        check("alu_count", bus.count, 2);
        check("alu_valid", bus.out_valid, 2'b11);
        check("alu_branch", bus.out_is_branch, 2'b00);
        check("alu_hilo", bus.out_is_hilo, 2'b00);
        check("alu_btype", bus.out_branch_type, {3'(B_INVA), 3'(B_INVA)});
        pop_n(2);

        // Lone branch waits for its delay slot.
        push1(32'h1022_0003, 32'h200);
        check("beq_count", bus.count, 1);
        check("beq_held", bus.out_valid, 2'b00);
        push1(32'h0085_1021, 32'h204);
        check("beq_valid", bus.out_valid, 2'b11);
        check("beq_btype", bus.out_branch_type[2:0], B_EQNE);
        check("beq_slot", bus.out_is_delay_slot[1], 1'b1);
        pop_n(2);

        // Jump-and-link chain, then HI/LO accessors.
        push1(32'h0C00_0010, 32'h300);
        push1(32'h0040_F809, 32'h304);
        check("jalr_held", bus.out_valid, 2'b01);
        push1(32'h3421_0001, 32'h308);
        check("jal_btype", bus.out_branch_type[2:0], B_JUMP);
        check("jal_link", bus.out_is_link[0], 1'b1);
        check("jalr_btype", bus.out_branch_type[5:3], B_JREG);
        check("jalr_link", bus.out_is_link[1], 1'b1);
        check("jalr_slot", bus.out_is_delay_slot[1], 1'b1);
        pop_n(2);
        check("ori_slot", bus.out_is_delay_slot[0], 1'b1);
        drive(2'b11, 32'h0000_4010, 32'h0085_0018, 32'h30C, 32'h310, 1, 1'b0);
        check("hilo_flags", bus.out_is_hilo, 2'b11);
        pop_n(2);

        // Fill to capacity, drop pushes while not ready, then wrap the pointers.
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 32'h0000_0021 | (k << 11), 32'h0000_0025 | (k << 11),
                  32'h400 + 8 * k, 32'h404 + 8 * k, 0, 1'b0);
        end
        check("full_count", bus.count, 8);
        check("full_not_ready", bus.in_ready, 1'b0);
        drive(2'b11, 32'h0000_0821, 32'h0000_0825, 32'h500, 32'h504, 0, 1'b0);
        check("full_drop", bus.count, 8);
        pop_n(1);
        check("seven_not_ready", bus.in_ready, 1'b0);
        drive(2'b01, 32'h0000_1021, 32'h0, 32'h508, 32'h0, 0, 1'b0);
        check("seven_drop", bus.count, 7);
        pop_n(2);
        check("five_ready", bus.in_ready, 1'b1);
        drive(2'b11, 32'h0000_1821, 32'h0000_1825, 32'h510, 32'h514, 2, 1'b0);
        check("push_pop_count", bus.count, 5);

        // Flush dominates a simultaneous push and pop, and clears the pending delay slot.
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b1);
        drive(2'b11, 32'h0000_2021, 32'h0000_2025, 32'h600, 32'h604, 0, 1'b0);
        drive(2'b11, 32'h0000_2821, 32'h0000_2825, 32'h608, 32'h60C, 0, 1'b0);
        push1(32'h1022_0003, 32'h610);
        check("pre_flush_count", bus.count, 5);
        drive(2'b11, 32'h0000_3021, 32'h0000_3025, 32'h700, 32'h704, 2, 1'b1);
        check("flush_count", bus.count, 0);
        check("flush_valid", bus.out_valid, 2'b00);
        check("flush_ready", bus.in_ready, 1'b1);
        push1(32'h0085_1021, 32'h800);
        check("flush_slot", bus.out_is_delay_slot[0], 1'b0);

        // Random traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            logic [1:0] v;
            int         r;
            r = $urandom_range(0, 9);
            v = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : 2'b11;
            drive(v, rand_instr(), rand_instr(), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, OUT_WIDTH), ($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset between clock edges.
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b1);
        drive(2'b11, 32'h0000_4021, 32'h0000_4025, 32'h900, 32'h904, 0, 1'b0);
        drive(2'b11, 32'h0000_4821, 32'h0000_4825, 32'h908, 32'h90C, 0, 1'b0);
        check("pre_rst_count", bus.count, 4);
        @(negedge clk);
        mon_en       = 1'b0;
        bus.in_valid = '0;
        bus.out_pop  = '0;
        bus.flush    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", bus.count, 0);
        check("async_rst_valid", bus.out_valid, 2'b00);
        check("async_rst_ready", bus.in_ready, 1'b1);
        exp_q.delete();
        prev_br = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        drive(2'b11, 32'h0000_5021, 32'h0000_5025, 32'hA00, 32'hA04, 0, 1'b0);
        check("post_rst_count", bus.count, 2);
        pop_n(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/predecode_fifo.md
Name: predecode_fifo

Overview:
- Parametrised successor to the single-instruction alpha decoder.
- Sits between fetch and the issue/decode stage. Accepts up to IN_WIDTH fetched instructions per cycle and predecodes each one: field split, branch class, link, HILO access and delay-slot tag.
- Predecoded entries are buffered in a circular queue of DEPTH entries.
- Presents up to OUT_WIDTH head entries per cycle to issue, with pop-count handshake and flush.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 2*IN_WIDTH.
- IN_WIDTH, 2, fetch lanes pushed per cycle (1 or 2).
- OUT_WIDTH, 2, issue lanes presented per cycle (1 or 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  discard all contents (redirect/exception).
- in_valid  in  IN_WIDTH  per-lane push valid; contiguous from lane 0.
- in_instr  in  32*IN_WIDTH  instruction words, lane i at [32i+31:32i].
- in_pc  in  32*IN_WIDTH  instruction addresses.
- in_ready  out  1  queue can accept a full IN_WIDTH push this cycle.
- out_valid  out  OUT_WIDTH  head lane i holds an issuable entry.
- out_instr  out  32*OUT_WIDTH  raw instruction of head+i.
- out_pc  out  32*OUT_WIDTH  pc of head+i.
- out_branch_type  out  3*OUT_WIDTH  `B_* class from common.vh.
- out_is_branch  out  OUT_WIDTH  branch/jump flag.
- out_is_link  out  OUT_WIDTH  writes link register.
- out_is_hilo  out  OUT_WIDTH  reads/writes HI/LO.
- out_is_delay_slot  out  OUT_WIDTH  entry immediately follows a branch.
- out_pop  in  $clog2(OUT_WIDTH+1)  number of head entries consumed this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async): head, tail, count = 0; prev_branch = 0; all storage zeroed. All out_* = 0; in_ready = 1.
- Predecode is combinational on push and stored with the entry. Let op=[31:26], rt=[20:16], fn=[5:0].
  - op[5:2]=0001: branch, B_EQNE, link 0.
  - Else op=000001 and rt[3:1]=000: branch, B_LTGE, link rt[4].
  - Else op[5:1]=00001: branch, B_JUMP, link op[0].
  - Else op=0 and fn[5:1]=00100: branch, B_JREG, link fn[0].
  - Else: not a branch, B_INVA, link 0.
  - hilo = (op=0 and fn[5:2] in {0100,0110}) or (op=011100 and fn[5:3]=000 and fn[2:0] in {000,001,010,100,101}).
- in_ready = (DEPTH - count) >= IN_WIDTH, computed from registered count. A pop in the same cycle is not credited.
- Push occurs when in_ready=1 and in_valid!=0; it writes popcount(in_valid) entries at tail. in_valid with a gap (e.g. 2'b10) is illegal; flag it with an assertion. When in_ready=0, in_valid is ignored and nothing is written.
- Delay-slot tag:
  - Lane 0 tag = prev_branch.
  - Lane i>0 tag = is_branch of lane i-1 in the same push.
  - prev_branch <= is_branch of the highest valid pushed lane; it is held when nothing is pushed.
- Latency: an entry pushed at edge N is visible on out_* after edge N (the next cycle). There is no combinational in->out bypass.
- out_valid[i] = (count > i) AND NOT (entry head+i is a branch AND count <= i+1). A branch is never presented without its delay slot in the queue.
  - out_valid must be prefix-contiguous: if lane i is invalid, lane i+1 is forced invalid.
  - out_* data fields for lanes with out_valid=0 are don't-care.
- Pop: head advances by out_pop and count updates to count + pushed - popped in one cycle. out_pop greater than the number of asserted out_valid lanes is illegal; flag it with an assertion.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH.
- Flush: head = tail = count = 0 and prev_branch = 0 at the next edge. Flush dominates any push or pop in the same cycle. in_ready returns to 1 the following cycle.
- Reset asserted mid-operation clears state immediately and asynchronously, independent of clk.

Test Plan:
- Reset, then push lanes {0x00000000, 0x00851020} at pc 0x100/0x104 -> after 1 cycle: count=2, out_valid=2'b11, out_is_branch=00, out_is_hilo=00, out_branch_type=B_INVA for both lanes.
- Push a lone BEQ 0x10220003 (in_valid=01) -> count=1, out_valid=00. Next cycle push ADDU 0x00851021 -> out_valid=11, lane0 B_EQNE, lane1 out_is_delay_slot=1.
- Push JAL 0x0C000010 and JALR 0x0040F809 with one push each cycle, then ORI 0x34210001 -> JAL: B_JUMP, link=1. JALR: B_JREG, link=1, delay_slot=1. ORI: delay_slot=1. MFHI 0x00004010 and MULT 0x00850018 give out_is_hilo=1.
- Fill DEPTH=8 with out_pop=0 -> in_ready=0 when count>=7. A push attempted while in_ready=0 is dropped (count stays 8). With out_pop=2 and a simultaneous push once in_ready=1: count=8-2+2, and pointers wrap with correct FIFO order.
- With count=5, assert flush together with in_valid=11 and out_pop=2 -> next cycle count=0, out_valid=00, in_ready=1. A following push of a non-branch has delay_slot=0.
- Assert rst between clock edges with count=4 -> count=0 and out_valid=0 immediately, without waiting for a clk edge.
